// File: rtl/sent_rx_crc_check.sv
// SENT receive-side CRC checker.
// Recomputes the frame CRC bit-serially (one message bit per clock) from the
// data nibbles extracted by the RX frame decoder, using the same seeds and
// polynomials as the TX generator, and reports match/mismatch to RX control.
//   CRC4: seed 4'b0101,   P = x^4+x^3+x^2+1 (5'b11101)
//   CRC6: seed 6'b010101, P = x^6+x^4+x^3+1 (7'b1011001)
module sent_rx_crc_check (
  input  logic        clk_rx,
  input  logic        reset_rx_n,
  input  logic [2:0]  enable_crc_check,
  input  logic [23:0] data_check_crc,
  input  logic [5:0]  crc_received,
  output logic [5:0]  crc_calc,
  output logic        crc_check_done,
  output logic        crc_ok,
  output logic        crc_error,
  output logic [1:0]  crc_check_mode
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_CHECK    = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  localparam logic [5:0] SEED4 = 6'h05;
  localparam logic [5:0] SEED6 = 6'h15;
  localparam logic [5:0] POLY4 = 6'h0D;  // x^4 term implied by the feedback bit
  localparam logic [5:0] POLY6 = 6'h19;  // x^6 term implied by the feedback bit

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_mode;
  logic [23:0] r_data;
  logic [5:0]  r_crc_rx;
  logic [5:0]  r_crc;
  logic [4:0]  r_cnt;

  logic        w_start;
  logic        w_start_valid;
  logic [23:0] w_data_aligned;
  logic [4:0]  w_cnt_init;
  logic [5:0]  w_seed;
  logic        w_crc6;
  logic        w_mode_valid;
  logic        w_fb;
  logic [5:0]  w_crc_next;
  logic [5:0]  w_calc;
  logic        w_match;
  logic [1:0]  w_mode_out;

  assign w_start       = (enable_crc_check != 3'b000);
  assign w_start_valid = w_start && (enable_crc_check <= 3'b101);

  // Left-align the used data bits so the shift always feeds bit 23; the zero
  // fill behind the data provides the augmentation zeros for free.
  always_comb begin
    w_data_aligned = '0;
    w_cnt_init     = '0;
    w_seed         = SEED4;
    case (enable_crc_check)
      3'b001: begin
        w_data_aligned = data_check_crc;
        w_cnt_init     = 5'd27;
      end
      3'b010: begin
        w_data_aligned = {data_check_crc[15:0], 8'h00};
        w_cnt_init     = 5'd19;
      end
      3'b011, 3'b100: begin
        w_data_aligned = {data_check_crc[11:0], 12'h000};
        w_cnt_init     = 5'd15;
      end
      3'b101: begin
        w_data_aligned = data_check_crc;
        w_cnt_init     = 5'd29;
        w_seed         = SEED6;
      end
      default: begin
        w_data_aligned = '0;
        w_cnt_init     = '0;
        w_seed         = '0;
      end
    endcase
  end

  assign w_crc6       = (r_mode == 3'b101);
  assign w_mode_valid = (r_mode != 3'b000) && (r_mode <= 3'b101);

  // One step of the division register: shift in the next message bit and
  // subtract the polynomial whenever the degree term falls out.
  always_comb begin
    w_fb       = w_crc6 ? r_crc[5] : r_crc[3];
    w_crc_next = '0;
    if (w_crc6) begin
      w_crc_next = {r_crc[4:0], r_data[23]} ^ (w_fb ? POLY6 : 6'h00);
    end else begin
      w_crc_next = {2'b00, r_crc[2:0], r_data[23]} ^ (w_fb ? POLY4 : 6'h00);
    end
  end

  // Result formatting and comparison for the CHECK cycle.
  always_comb begin
    w_calc     = '0;
    w_match    = 1'b0;
    w_mode_out = 2'b00;
    case (r_mode)
      3'b001, 3'b010, 3'b011: begin
        w_calc     = {2'b00, r_crc[3:0]};
        w_match    = (r_crc[3:0] == r_crc_rx[3:0]);
        w_mode_out = 2'b01;
      end
      3'b100: begin
        w_calc     = {2'b00, r_crc[3:0]};
        w_match    = (r_crc[3:0] == r_crc_rx[3:0]);
        w_mode_out = 2'b10;
      end
      3'b101: begin
        w_calc     = r_crc;
        w_match    = (r_crc == r_crc_rx);
        w_mode_out = 2'b11;
      end
      default: begin
        w_calc     = '0;
        w_match    = 1'b0;
        w_mode_out = 2'b00;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_rx or negedge reset_rx_n) begin
    if (!reset_rx_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; invalid modes skip straight to CHECK.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = w_start_valid ? ST_SHIFT : ST_CHECK;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == 5'd0) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_state_next = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!w_start) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the job on start, then run the bit-serial division in SHIFT.
  always_ff @(posedge clk_rx or negedge reset_rx_n) begin
    if (!reset_rx_n) begin
      r_mode   <= '0;
      r_data   <= '0;
      r_crc_rx <= '0;
      r_crc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_mode   <= enable_crc_check;
            r_data   <= w_data_aligned;
            r_crc_rx <= crc_received;
            r_crc    <= w_seed;
            r_cnt    <= w_cnt_init;
          end
        end
        ST_SHIFT: begin
          r_crc  <= w_crc_next;
          r_data <= {r_data[22:0], 1'b0};
          r_cnt  <= r_cnt - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result outputs update only in CHECK and hold otherwise; done is a pulse.
  always_ff @(posedge clk_rx or negedge reset_rx_n) begin
    if (!reset_rx_n) begin
      crc_calc       <= '0;
      crc_check_done <= 1'b0;
      crc_ok         <= 1'b0;
      crc_error      <= 1'b0;
      crc_check_mode <= '0;
    end else begin
      crc_check_done <= 1'b0;
      if (r_state == ST_CHECK) begin
        crc_calc       <= w_calc;
        crc_check_done <= 1'b1;
        crc_ok         <= w_mode_valid && w_match;
        crc_error      <= !(w_mode_valid && w_match);
        crc_check_mode <= w_mode_out;
      end
    end
  end

endmodule

// File: tb/tb_sent_rx_crc_check.sv
// Directed and model-based bench for sent_rx_crc_check.
module tb_sent_rx_crc_check;

  logic        clk_rx;
  logic        reset_rx_n;
  logic [2:0]  enable_crc_check;
  logic [23:0] data_check_crc;
  logic [5:0]  crc_received;
  logic [5:0]  crc_calc;
  logic        crc_check_done;
  logic        crc_ok;
  logic        crc_error;
  logic [1:0]  crc_check_mode;

  int checks   = 0;
  int failures = 0;

  sent_rx_crc_check dut (
    .clk_rx           (clk_rx),
    .reset_rx_n       (reset_rx_n),
    .enable_crc_check (enable_crc_check),
    .data_check_crc   (data_check_crc),
    .crc_received     (crc_received),
    .crc_calc         (crc_calc),
    .crc_check_done   (crc_check_done),
    .crc_ok           (crc_ok),
    .crc_error        (crc_error),
    .crc_check_mode   (crc_check_mode)
  );

  initial clk_rx = 1'b0;
  always #5 clk_rx = ~clk_rx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Long division of {seed, data, zeros} by the full polynomial, MSB first.
  function automatic logic [5:0] model_crc(input logic [2:0] m, input logic [23:0] d);
    int unsigned dbits;
    int unsigned deg;
    logic [63:0] msg;
    logic [63:0] poly;
    logic [63:0] seed;
    dbits = 24; deg = 4; poly = 64'h1D; seed = 64'h5;
    case (m)
      3'd2: dbits = 16;
      3'd3, 3'd4: dbits = 12;
      3'd5: begin deg = 6; poly = 64'h59; seed = 64'h15; end
      default: dbits = 24;
    endcase
    msg = seed;
    for (int i = int'(dbits) - 1; i >= 0; i--) msg = (msg << 1) | 64'(d[i]);
    msg = msg << deg;
    for (int i = int'(deg + dbits + deg) - 1; i >= int'(deg); i--) begin
      if (msg[i]) msg = msg ^ (poly << (i - int'(deg)));
    end
    msg = msg & ((64'd1 << deg) - 64'd1);
    return msg[5:0];
  endfunction

  function automatic logic [1:0] model_mode(input logic [2:0] m);
    case (m)
      3'd1, 3'd2, 3'd3: return 2'b01;
      3'd4:             return 2'b10;
      3'd5:             return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  // Start a job, count clock edges after the start edge until done, check results.
  task automatic run_job(input string tag, input logic [2:0] m, input logic [23:0] d,
                         input logic [5:0] rx, input int exp_cyc, input logic [5:0] exp_calc,
                         input logic exp_ok, input logic [1:0] exp_mode, input bit toggle);
    int cyc;
    enable_crc_check = m;
    data_check_crc   = d;
    crc_received     = rx;
    @(posedge clk_rx);
    #1;
    cyc = 999;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk_rx);
      #1;
      if (toggle && i == 3) begin
        data_check_crc = ~d;
        crc_received   = ~rx;
      end
      if (crc_check_done) begin
        cyc = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_calc"}, 32'(crc_calc), 32'(exp_calc));
    check({tag, "_ok"}, 32'(crc_ok), 32'(exp_ok));
    check({tag, "_err"}, 32'(crc_error), 32'(!exp_ok));
    check({tag, "_mode"}, 32'(crc_check_mode), 32'(exp_mode));
    enable_crc_check = 3'b000;
    repeat (2) @(posedge clk_rx);
    #1;
  endtask

  initial begin
    int pulses;
    logic [23:0] rd;
    logic [5:0]  rrx;
    logic [5:0]  exp_c;
    int n;

    reset_rx_n       = 1'b0;
    enable_crc_check = 3'b000;
    data_check_crc   = '0;
    crc_received     = '0;
    repeat (3) @(posedge clk_rx);
    #1;
    check("rst_calc", 32'(crc_calc), 32'h0);
    check("rst_done", 32'(crc_check_done), 32'h0);
    check("rst_ok", 32'(crc_ok), 32'h0);
    check("rst_err", 32'(crc_error), 32'h0);
    check("rst_mode", 32'(crc_check_mode), 32'h0);
    @(negedge clk_rx);
    reset_rx_n = 1'b1;
    repeat (2) @(posedge clk_rx);
    #1;

    // Zero-data, all modes.
    run_job("m3_zero", 3'd3, 24'h0, 6'h09, 17, 6'h09, 1'b1, 2'b01, 1'b0);
    run_job("m2_zero", 3'd2, 24'h0, 6'h0C, 21, 6'h0C, 1'b1, 2'b01, 1'b0);
    run_job("m1_zero", 3'd1, 24'h0, 6'h05, 29, 6'h05, 1'b1, 2'b01, 1'b0);
    run_job("m4_zero", 3'd4, 24'h0, 6'h09, 17, 6'h09, 1'b1, 2'b10, 1'b0);
    run_job("m5_zero", 3'd5, 24'h0, 6'h26, 31, 6'h26, 1'b1, 2'b11, 1'b0);
    run_job("m5_bad",  3'd5, 24'h0, 6'h27, 31, 6'h26, 1'b0, 2'b11, 1'b0);

    // Single data bit and ignored upper received bits in CRC4.
    run_job("m3_one",    3'd3, 24'h000001, 6'h04, 17, 6'h04, 1'b1, 2'b01, 1'b0);
    run_job("m3_ign",    3'd3, 24'h000001, 6'h34, 17, 6'h04, 1'b1, 2'b01, 1'b0);
    run_job("m3_bad",    3'd3, 24'h000001, 6'h08, 17, 6'h04, 1'b0, 2'b01, 1'b0);
    // Upper data bits unused in 12-bit mode.
    run_job("m3_hiign",  3'd3, 24'hFFF001, 6'h04, 17, 6'h04, 1'b1, 2'b01, 1'b0);

    // Invalid modes.
    run_job("m6_inv", 3'd6, 24'h123456, 6'h00, 1, 6'h00, 1'b0, 2'b00, 1'b0);
    run_job("m7_inv", 3'd7, 24'hABCDEF, 6'h3F, 1, 6'h00, 1'b0, 2'b00, 1'b0);

    // Level held high gives one pulse; drop and reassert gives another.
    enable_crc_check = 3'd5;
    data_check_crc   = 24'h0;
    crc_received     = 6'h26;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_rx);
      #1;
      if (crc_check_done) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    enable_crc_check = 3'd0;
    repeat (3) @(posedge clk_rx);
    #1;
    enable_crc_check = 3'd5;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_rx);
      #1;
      if (crc_check_done) pulses++;
    end
    check("retrig_pulses", 32'(pulses), 32'd1);
    check("retrig_ok", 32'(crc_ok), 32'd1);
    enable_crc_check = 3'd0;
    repeat (3) @(posedge clk_rx);
    #1;

    // Reset in the middle of SHIFT.
    enable_crc_check = 3'd5;
    data_check_crc   = 24'h123456;
    crc_received     = 6'h00;
    @(posedge clk_rx);
    repeat (10) @(posedge clk_rx);
    #2;
    reset_rx_n       = 1'b0;
    enable_crc_check = 3'd0;
    #1;
    check("midrst_calc", 32'(crc_calc), 32'h0);
    check("midrst_ok", 32'(crc_ok), 32'h0);
    check("midrst_err", 32'(crc_error), 32'h0);
    check("midrst_mode", 32'(crc_check_mode), 32'h0);
    check("midrst_done", 32'(crc_check_done), 32'h0);
    @(negedge clk_rx);
    reset_rx_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_rx);
      #1;
      if (crc_check_done) pulses++;
    end
    check("midrst_nopulse", 32'(pulses), 32'd0);
    run_job("post_rst", 3'd3, 24'h000001, 6'h04, 17, 6'h04, 1'b1, 2'b01, 1'b0);

    // Inputs changing during SHIFT must not affect the result.
    exp_c = model_crc(3'd1, 24'hA5C31E);
    run_job("toggle_m1", 3'd1, 24'hA5C31E, exp_c, 29, exp_c, 1'b1, 2'b01, 1'b1);
    exp_c = model_crc(3'd5, 24'h3C9A71);
    run_job("toggle_m5", 3'd5, 24'h3C9A71, exp_c, 31, exp_c, 1'b1, 2'b11, 1'b1);

    // Random sweep across all valid modes against the long-division model.
    for (int m = 1; m <= 5; m++) begin
      for (int k = 0; k < 4; k++) begin
        rd    = 24'($urandom);
        exp_c = model_crc(3'(m), rd);
        rrx   = (k == 3) ? (exp_c ^ 6'h01) : exp_c;
        case (m)
          1: n = 29;
          2: n = 21;
          5: n = 31;
          default: n = 17;
        endcase
        run_job($sformatf("sweep_m%0d_%0d", m, k), 3'(m), rd, rrx, n, exp_c,
                (k != 3), model_mode(3'(m)), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
